subreg_tim_sched: RTL and testbench
===================================

# subreg_tim_sched

Time-multiplexed scheduler that shares one sub-regulation (evenly spread N-of-M) tick accumulator datapath among C_CH_N channels, e.g. per-LED-digit refresh, key-scan and serial-bit ticks on the TM1638 side. A slot counter visits channels round-robin, one per clock. Each visit updates that channel's signed accumulator and emits a one-cycle enable pulse when it is due. A req/ack port reconfigures one channel's rate at its slot boundary, so no partial-period glitch reaches other channels.

## Interface
- C_CH_N, 4, number of channels (≥2)
- C_PERIOD_W, 16, width of PERIOD/PULSE_N; accumulator is C_PERIOD_W+1 bits signed
- C_CH_W, clog2(C_CH_N), channel index width (derived)

Ports:
- CK_i  in  1  clock
- XARST_i  in  1  asynchronous reset, active low
- RST_i  in  1  synchronous reset, active high
- CH_EN_i  in  C_CH_N  per-channel run enable; low holds accumulator, no pulses
- CFG_REQ_i  in  1  config request, held until ack
- CFG_CH_i  in  C_CH_W  target channel, stable while REQ high
- CFG_PERIOD_i  in  C_PERIOD_W  slots per period M; 0 = channel off
- CFG_PULSE_N_i  in  C_PERIOD_W  pulses per period N
- CFG_ACK_o  out  1  one-cycle config accepted
- EN_CK_o  out  C_CH_N  one-cycle tick per channel, at most one bit high
- SLOT_o  out  C_CH_W  channel evaluated this cycle
- FRAME_o  out  1  one-cycle pulse when SLOT_o wraps to 0

## Operation
- Per channel state: PERIOD[c], PULSE_N[c], ACC[c] (signed C_PERIOD_W+1).
- Init value: INIT = (PERIOD − PULSE_N) >>> 1, computed at C_PERIOD_W+1 signed width.
- Slot s = SLOT_o, advancing 0..C_CH_N−1 and wrapping to 0 every clock.
- Normal update in slot s, when CH_EN_i[s]=1, PERIOD[s]≠0 and no config hit:
  - due = ACC[s][MSB], i.e. the accumulator is negative.
  - ACC[s] ← ACC[s] − PULSE_N[s] + (due ? PERIOD[s] : 0).
  - EN_CK_o ← onehot(s) & due.
- Disabled or PERIOD=0: ACC held, no pulse.
- Config hit: CFG_REQ_i=1 and CFG_CH_i=s, with no RST_i.
  - PERIOD[s] ← CFG_PERIOD_i.
  - PULSE_N[s] ← min(CFG_PULSE_N_i, CFG_PERIOD_i). The clamp makes N≥M tick every slot.
  - ACC[s] ← INIT of the new values.
  - No pulse from s this slot; CFG_ACK_o ← 1.
- With PULSE_N≤PERIOD, ACC stays within [−PULSE_N, PERIOD−1]. There is no overflow at the stated width.
- Average rate per channel is PULSE_N/PERIOD ticks per C_CH_N clocks. Ticks are spread as evenly as possible, with maximal jitter of one slot visit.
- RST_i: every ACC[c] ← INIT(c) from the retained config, SLOT ← 0, outputs ← 0. Pending REQ is not acked that cycle; RST_i wins over a simultaneous request.
- XARST_i low: all PERIOD, PULSE_N and ACC ← 0, SLOT ← 0, all outputs 0. Every channel is therefore off until configured.

## Timing
- Reset values: EN_CK_o=0, CFG_ACK_o=0, FRAME_o=0, SLOT_o=0.
- EN_CK_o, CFG_ACK_o and FRAME_o are registered. Each appears the cycle after the slot that produced it.
- FRAME_o rises together with SLOT_o=0.
- Config ack latency: 1 to C_CH_N cycles after REQ rises.
- After the ack the master must drop REQ or change CFG_CH_i. A REQ still high on the same channel re-hits one frame later (legal, reinitializes).
- The first post-config tick comes no earlier than the next visit of that channel.
- Deasserting CH_EN_i mid-period freezes ACC exactly. Reasserting resumes the sequence.

## Structure
- Shared package holds:
  - the C_CH_W derivation (clog2);
  - function init_acc(period, pulse_n) returning the signed INIT;
  - function acc_next(acc, period, pulse_n) returning {due, acc'}.
- One natural sub-module, subreg_tim_acc_upd: the combinational accumulator update for one slot, instantiated once and shared by all channels.
- Config and ACC arrays are flops; a C_CH_N-deep register file is acceptable for large C_CH_N.

## Test plan
- Period 7, 3 pulses: C_CH_N=4, C_PERIOD_W=3, configure ch0 with PERIOD=7, PULSE_N=3.
  - ACC visits 2,−1,3,0,−3,1,−2 and then repeats.
  - Ticks occur on visits 1, 4 and 6 after the ack, i.e. exactly 3 ticks per 7 visits.
- Clamp: configure PERIOD=5, PULSE_N=9 on ch2. EN_CK_o[2] pulses on every visit, every 4 clocks.
- Concurrent channels: ch1 on 1/2, ch3 on 2/3.
  - Never two EN_CK_o bits in the same cycle.
  - Over 600 clocks, ch1 gives 75 and ch3 gives 100 ticks, ±1.
- Config timing: raise REQ for ch3 while SLOT_o=0.
  - ACK appears the cycle after SLOT_o=3.
  - No ch3 tick that slot; other channels are unaffected.
- Resets:
  - RST_i asserted together with REQ: no ACK, SLOT_o=0, ACC reloaded from old config.
  - XARST_i low mid-run: all outputs 0 at once, and every channel stays silent until reconfigured.

Source files
------------

// File: rtl/subreg_tim_sched_pkg.sv
// subreg_tim_sched_pkg: shared widths and accumulator arithmetic for the tick scheduler
package subreg_tim_sched_pkg;
    localparam int C_CH_N_DEF     = 4;
    localparam int C_PERIOD_W_DEF = 16;

    typedef struct packed {
        logic               due;
        logic signed [31:0] acc;
    } acc_upd_t;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Computed wide, callers truncate to C_PERIOD_W+1; the true value always fits
    function automatic int init_acc(input int period, input int pulse_n);
        return (period - pulse_n) >>> 1;
    endfunction

    function automatic acc_upd_t acc_next(input int acc, input int period, input int pulse_n);
        acc_next.due = acc < 0;
        acc_next.acc = acc - pulse_n + ((acc < 0) ? period : 0);
    endfunction
endpackage

// File: rtl/subreg_tim_sched_if.sv
// subreg_tim_sched_if: channel rate reconfiguration req/ack handshake
interface subreg_tim_sched_if #(
    parameter int C_CH_W     = 2,
    parameter int C_PERIOD_W = 16
);
    logic                  CFG_REQ;
    logic [C_CH_W-1:0]     CFG_CH;
    logic [C_PERIOD_W-1:0] CFG_PERIOD;
    logic [C_PERIOD_W-1:0] CFG_PULSE_N;
    logic                  CFG_ACK;

    modport master (output CFG_REQ, CFG_CH, CFG_PERIOD, CFG_PULSE_N, input CFG_ACK);
    modport slave  (input CFG_REQ, CFG_CH, CFG_PERIOD, CFG_PULSE_N, output CFG_ACK);
endinterface

// File: rtl/subreg_tim_acc_upd.sv
// subreg_tim_acc_upd: combinational accumulator step for the channel in the current slot
module subreg_tim_acc_upd
    import subreg_tim_sched_pkg::*;
#(
    parameter int C_PERIOD_W = C_PERIOD_W_DEF
) (
    input  logic signed [C_PERIOD_W:0]   ACC,
    input  logic        [C_PERIOD_W-1:0] PERIOD,
    input  logic        [C_PERIOD_W-1:0] PULSE_N,
    output logic                         DUE,
    output logic signed [C_PERIOD_W:0]   ACC_NXT
);
    acc_upd_t upd;

    always_comb begin
        upd     = acc_next(int'(ACC), int'(PERIOD), int'(PULSE_N));
        DUE     = upd.due;
        ACC_NXT = (C_PERIOD_W+1)'(upd.acc);
    end
endmodule

// File: rtl/subreg_tim_sched.sv
// subreg_tim_sched: round-robin N-of-M tick scheduler sharing one accumulator datapath
module subreg_tim_sched
    import subreg_tim_sched_pkg::*;
#(
    parameter int  C_CH_N     = C_CH_N_DEF,
    parameter int  C_PERIOD_W = C_PERIOD_W_DEF,
    localparam int C_CH_W     = ch_w(C_CH_N)
) (
    input  logic              CK_i,
    input  logic              XARST_i,
    input  logic              RST_i,
    input  logic [C_CH_N-1:0] CH_EN_i,
    subreg_tim_sched_if.slave cfg,
    output logic [C_CH_N-1:0] EN_CK_o,
    output logic [C_CH_W-1:0] SLOT_o,
    output logic              FRAME_o
);
    localparam logic [C_CH_W-1:0] C_LAST = C_CH_W'(C_CH_N - 1);

    logic        [C_CH_W-1:0]     slot;
    logic        [C_PERIOD_W-1:0] period_q [C_CH_N];
    logic        [C_PERIOD_W-1:0] pulse_q  [C_CH_N];
    logic signed [C_PERIOD_W:0]   acc_q    [C_CH_N];
    logic                         hit, run, due;
    logic signed [C_PERIOD_W:0]   acc_nxt, acc_init;
    logic        [C_PERIOD_W-1:0] pulse_cl;

    subreg_tim_acc_upd #(.C_PERIOD_W(C_PERIOD_W)) u_upd (
        .ACC     (acc_q[slot]),
        .PERIOD  (period_q[slot]),
        .PULSE_N (pulse_q[slot]),
        .DUE     (due),
        .ACC_NXT (acc_nxt)
    );

    assign hit      = cfg.CFG_REQ && (cfg.CFG_CH == slot);
    assign run      = CH_EN_i[slot] && (period_q[slot] != '0);
    // N >= M is clamped so the channel ticks every visit instead of overflowing
    assign pulse_cl = (cfg.CFG_PULSE_N > cfg.CFG_PERIOD) ? cfg.CFG_PERIOD : cfg.CFG_PULSE_N;
    assign acc_init = (C_PERIOD_W+1)'(init_acc(int'(cfg.CFG_PERIOD), int'(pulse_cl)));
    assign SLOT_o   = slot;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            slot        <= '0;
            EN_CK_o     <= '0;
            FRAME_o     <= 1'b0;
            cfg.CFG_ACK <= 1'b0;
            for (int c = 0; c < C_CH_N; c++) begin
                period_q[c] <= '0;
                pulse_q[c]  <= '0;
                acc_q[c]    <= '0;
            end
        end else if (RST_i) begin
            slot        <= '0;
            EN_CK_o     <= '0;
            FRAME_o     <= 1'b0;
            cfg.CFG_ACK <= 1'b0;
            for (int c = 0; c < C_CH_N; c++)
                acc_q[c] <= (C_PERIOD_W+1)'(init_acc(int'(period_q[c]), int'(pulse_q[c])));
        end else begin
            slot        <= (slot == C_LAST) ? '0 : slot + C_CH_W'(1);
            FRAME_o     <= slot == C_LAST;
            cfg.CFG_ACK <= hit;
            EN_CK_o     <= (run && !hit && due) ? C_CH_N'(1) << slot : '0;
            if (hit) begin
                period_q[slot] <= cfg.CFG_PERIOD;
                pulse_q[slot]  <= pulse_cl;
                acc_q[slot]    <= acc_init;
            end else if (run) begin
                acc_q[slot] <= acc_nxt;
            end
        end
    end
endmodule

// File: tb/tb_subreg_tim_sched.sv
// tb_subreg_tim_sched: table vectors, directed corner sequences and a closed-form random reference
module tb_subreg_tim_sched;
    localparam int CN = 4;
    localparam int PW = 4;

    logic          CK_i = 1'b0;
    logic          XARST_i, RST_i;
    logic [CN-1:0] CH_EN_i, EN_CK_o;
    logic [1:0]    SLOT_o;
    logic          FRAME_o;

    subreg_tim_sched_if #(.C_CH_W(2), .C_PERIOD_W(PW)) cfg ();

    subreg_tim_sched #(.C_CH_N(CN), .C_PERIOD_W(PW)) dut (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .RST_i   (RST_i),
        .CH_EN_i (CH_EN_i),
        .cfg     (cfg),
        .EN_CK_o (EN_CK_o),
        .SLOT_o  (SLOT_o),
        .FRAME_o (FRAME_o)
    );

    always #5 CK_i = ~CK_i;

    int n_vec = 0, n_err = 0;

    // Reference: per channel M, N and the number of counted visits k since (re)init
    int            mm[CN], mn[CN], mk[CN], ms;
    logic [CN-1:0] e_en;
    logic          e_ack, e_frame;
    logic [1:0]    e_slot;

    function automatic int cdiv(input int a, input int m);
        return (a >= 0) ? (a + m - 1) / m : -((-a) / m);
    endfunction

    // Ticks in the first j visits of an evenly spread N-of-M sequence starting at (M-N)/2
    function automatic int ticks(input int m, input int n, input int j);
        int t;
        if (j == 0) return 0;
        t = cdiv((j - 1) * n - (m - n) / 2, m);
        return (t > 0) ? t : 0;
    endfunction

    task automatic model_areset();
        for (int c = 0; c < CN; c++) begin
            mm[c] = 0; mn[c] = 0; mk[c] = 0;
        end
        ms = 0; e_en = '0; e_ack = 0; e_frame = 0; e_slot = 0;
    endtask

    task automatic model_step();
        int s, p, n;
        if (!XARST_i) begin
            model_areset();
        end else if (RST_i) begin
            for (int c = 0; c < CN; c++) mk[c] = 0;
            ms = 0; e_en = '0; e_ack = 0; e_frame = 0;
        end else begin
            s = ms;
            e_en = '0;
            e_frame = (s == CN - 1);
            e_ack = cfg.CFG_REQ && (int'(cfg.CFG_CH) == s);
            if (e_ack) begin
                p = int'(cfg.CFG_PERIOD);
                n = int'(cfg.CFG_PULSE_N);
                mm[s] = p; mn[s] = (n > p) ? p : n; mk[s] = 0;
            end else if (CH_EN_i[s] && mm[s] != 0) begin
                e_en[s] = (ticks(mm[s], mn[s], mk[s] + 1) != ticks(mm[s], mn[s], mk[s]));
                mk[s]++;
            end
            ms = (s + 1) % CN;
        end
        e_slot = ms[1:0];
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        n_vec++;
        if (EN_CK_o !== e_en || cfg.CFG_ACK !== e_ack || FRAME_o !== e_frame || SLOT_o !== e_slot) begin
            n_err++;
            $display("FAIL cycle @%0t: en=%b ack=%b frame=%b slot=%0d, required en=%b ack=%b frame=%b slot=%0d",
                     $time, EN_CK_o, cfg.CFG_ACK, FRAME_o, SLOT_o, e_en, e_ack, e_frame, e_slot);
        end
        n_vec++;
        if (!$onehot0(EN_CK_o)) begin
            n_err++;
            $display("FAIL onehot @%0t: en=%b, required at most one bit", $time, EN_CK_o);
        end
    endtask

    task automatic step();
        @(negedge CK_i);
        model_step();
        @(posedge CK_i);
        #1;
        check_cycle();
    endtask

    task automatic configure(input int c, input int p, input int n);
        bit seen = 0;
        cfg.CFG_REQ = 1; cfg.CFG_CH = 2'(c); cfg.CFG_PERIOD = PW'(p); cfg.CFG_PULSE_N = PW'(n);
        for (int i = 0; i < 2 * CN && !seen; i++) begin
            step();
            seen = cfg.CFG_ACK;
        end
        cfg.CFG_REQ = 0;
        chk($sformatf("cfg_ack_ch%0d", c), int'(seen), 1);
    endtask

    typedef struct {
        int ch;
        int period;
        int pulse;
        int visits;
        int mask;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int got, c1, c3, acks, quiet;
        tbl[0] = '{0, 7, 3, 14, 'h2952};
        tbl[1] = '{2, 5, 9, 8, 'hFE};
        tbl[2] = '{1, 2, 1, 8, 'hAA};
        tbl[3] = '{3, 3, 2, 8, 'hB6};
        tbl[4] = '{1, 0, 3, 8, 'h00};
        tbl[5] = '{0, 15, 1, 10, 'h100};

        XARST_i = 0; RST_i = 0; CH_EN_i = '0;
        cfg.CFG_REQ = 0; cfg.CFG_CH = 0; cfg.CFG_PERIOD = 0; cfg.CFG_PULSE_N = 0;
        model_areset();
        repeat (2) step();
        chk("reset_slot", int'(SLOT_o), 0);
        chk("reset_en", int'(EN_CK_o), 0);
        chk("reset_ack", int'(cfg.CFG_ACK), 0);
        chk("reset_frame", int'(FRAME_o), 0);
        XARST_i = 1;
        CH_EN_i = '1;
        repeat (8) step();
        chk("unconfigured_silent", int'(EN_CK_o), 0);

        foreach (tbl[t]) begin
            configure(tbl[t].ch, tbl[t].period, tbl[t].pulse);
            got = 0;
            for (int v = 0; v < tbl[t].visits; v++) begin
                repeat (CN) step();
                got |= int'(EN_CK_o[tbl[t].ch]) << v;
            end
            chk($sformatf("tbl%0d_mask", t), got, tbl[t].mask);
        end

        configure(0, 0, 0);
        configure(2, 0, 0);
        configure(1, 2, 1);
        configure(3, 3, 2);
        c1 = 0; c3 = 0;
        repeat (600) begin
            step();
            c1 += int'(EN_CK_o[1]);
            c3 += int'(EN_CK_o[3]);
        end
        chk("ch1_ticks_600", (c1 >= 74 && c1 <= 76) ? 75 : c1, 75);
        chk("ch3_ticks_600", (c3 >= 99 && c3 <= 101) ? 100 : c3, 100);

        for (int i = 0; i < 2 * CN && SLOT_o != 0; i++) step();
        chk("sync_slot0", int'(SLOT_o), 0);
        cfg.CFG_REQ = 1; cfg.CFG_CH = 3; cfg.CFG_PERIOD = 3; cfg.CFG_PULSE_N = 1;
        acks = 0;
        repeat (3) begin
            step();
            acks += int'(cfg.CFG_ACK);
        end
        chk("ack_early", acks, 0);
        step();
        chk("ack_after_slot3", int'(cfg.CFG_ACK), 1);
        chk("no_tick_cfg_slot", int'(EN_CK_o[3]), 0);
        cfg.CFG_REQ = 0;

        configure(0, 7, 3);
        repeat (13) step();
        RST_i = 1; cfg.CFG_REQ = 1; cfg.CFG_CH = e_slot; cfg.CFG_PERIOD = 5; cfg.CFG_PULSE_N = 5;
        step();
        RST_i = 0; cfg.CFG_REQ = 0;
        chk("rst_req_no_ack", int'(cfg.CFG_ACK), 0);
        chk("rst_slot", int'(SLOT_o), 0);
        chk("rst_en", int'(EN_CK_o), 0);
        got = 0;
        for (int v = 0; v < 7; v++) begin
            step();
            got |= int'(EN_CK_o[0]) << v;
            repeat (CN - 1) step();
        end
        chk("rst_reload_mask", got, 'h52);

        repeat (5) step();
        #2 XARST_i = 0;
        #1;
        model_areset();
        chk("xarst_en", int'(EN_CK_o), 0);
        chk("xarst_ack", int'(cfg.CFG_ACK), 0);
        chk("xarst_frame", int'(FRAME_o), 0);
        chk("xarst_slot", int'(SLOT_o), 0);
        repeat (2) step();
        XARST_i = 1;
        quiet = 0;
        repeat (40) begin
            CH_EN_i = CN'($urandom);
            step();
            quiet += int'(EN_CK_o != 0);
        end
        chk("silent_after_xarst", quiet, 0);

        repeat (2500) begin
            for (int c = 0; c < CN; c++) CH_EN_i[c] = ($urandom_range(0, 7) != 0);
            RST_i = ($urandom_range(0, 199) == 0);
            if (cfg.CFG_REQ && e_ack) cfg.CFG_REQ = 0;
            else if (!cfg.CFG_REQ && $urandom_range(0, 15) == 0) begin
                cfg.CFG_REQ = 1;
                cfg.CFG_CH = 2'($urandom_range(0, CN - 1));
                cfg.CFG_PERIOD = PW'($urandom_range(0, 15));
                cfg.CFG_PULSE_N = PW'($urandom_range(0, 15));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
